// File: rtl/parity_frame_rx.sv
// Framed serial receiver: start, WIDTH data bits LSB first, parity, stop.
// Recomputes parity over the received word and flags parity and framing errors.
//
// state  | meaning
// IDLE   | waiting for a start bit (rx=0) on a strobe
// DATA   | shifting in data bits, cnt selects the bit position
// PARITY | capturing the received parity bit
// STOP   | sampling stop bit, publishing data_out/errors, pulsing valid
module parity_frame_rx #(
  parameter int WIDTH      = 10,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             rx,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic             pbit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      pbit       <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // valid is a single-clock pulse independent of the strobe rate
      valid <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!rx) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            shift[cnt] <= rx;
            if (cnt == CW'(WIDTH - 1)) state <= PARITY;
            else                       cnt   <= cnt + 1'b1;
          end
          PARITY: begin
            pbit  <= rx;
            state <= STOP;
          end
          STOP: begin
            data_out   <= shift;
            parity_err <= (pbit != ((^shift) ^ PARITY_ODD));
            frame_err  <= ~rx;
            valid      <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: an even-parity and an odd-parity instance
// share the same serial stream; frame tables plus hand-written corner sequences.
module tb_parity_frame_rx;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bit_en = 1'b0;
  logic         rx = 1'b1;
  logic [W-1:0] data_out0, data_out1;
  logic         valid0, valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt0 = 0;
  int vcnt1 = 0;
  bit dsel  = 1'b0;

  logic [W-1:0] o_data;
  logic         o_valid, o_perr, o_ferr, o_busy;

  assign o_data  = dsel ? data_out1 : data_out0;
  assign o_valid = dsel ? valid1 : valid0;
  assign o_perr  = dsel ? perr1  : perr0;
  assign o_ferr  = dsel ? ferr1  : ferr0;
  assign o_busy  = dsel ? busy1  : busy0;

  always #5 clk = ~clk;

  parity_frame_rx #(.WIDTH(W), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
    .data_out(data_out0), .valid(valid0), .parity_err(perr0),
    .frame_err(ferr0), .busy(busy0)
  );

  parity_frame_rx #(.WIDTH(W), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
    .data_out(data_out1), .valid(valid1), .parity_err(perr1),
    .frame_err(ferr1), .busy(busy1)
  );

  always @(negedge clk) begin
    if (valid0) vcnt0++;
    if (valid1) vcnt1++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at posedge+1; drives one strobe and returns at posedge+1 of the last clock.
  task automatic strobe(input logic b, input int gap);
    rx = b;
    bit_en = 1'b1;
    @(posedge clk); #1;
    if (gap > 1) begin
      bit_en = 1'b0;
      for (int i = 1; i < gap; i++) begin
        rx = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic p, input logic stop,
                            input int gap, input logic exp_pe, input logic exp_fe,
                            input string tag);
    int early = 0;
    strobe(1'b0, gap);
    chk({tag, "_busy_start"}, 32'(o_busy), 32'd1);
    for (int i = 0; i < W; i++) begin
      strobe(d[i], gap);
      if (o_valid) early++;
    end
    strobe(p, gap);
    if (o_valid) early++;
    rx = stop;
    bit_en = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_data"},  32'(o_data),  32'(d));
    chk({tag, "_perr"},  32'(o_perr),  32'(exp_pe));
    chk({tag, "_ferr"},  32'(o_ferr),  32'(exp_fe));
    chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    chk({tag, "_early_valid"}, 32'(early), 32'd0);
    if (gap > 1) begin
      bit_en = 1'b0;
      rx = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk({tag, "_valid_width"}, 32'(o_valid), 32'd0);
      for (int i = 2; i < gap; i++) begin
        rx = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         p;
    logic         stop;
    logic         pe;
    logic         fe;
  } vec_t;

  vec_t tbl[8];
  int   v;
  logic [W-1:0] dd;

  initial begin
    tbl[0] = '{10'h149, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{10'h149, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{10'h3FF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{10'h001, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{10'h001, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{10'h2AA, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{10'h200, 1'b0, 1'b0, 1'b1, 1'b1};

    #12;
    chk("rst_data",  32'(data_out0), 32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_perr",  32'(perr0), 32'd0);
    chk("rst_ferr",  32'(ferr0), 32'd0);
    chk("rst_busy",  32'(busy0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) begin
      send_frame(tbl[k].d, tbl[k].p, tbl[k].stop, 1, tbl[k].pe, tbl[k].fe, $sformatf("tbl%0d", k));
      strobe(1'b1, 1);
      chk($sformatf("tbl%0d_valid_drop", k), 32'(valid0), 32'd0);
      chk($sformatf("tbl%0d_hold_data", k), 32'(data_out0), 32'(tbl[k].d));
    end

    // Break: stop sampled low, line stays low so the next strobe is a start bit.
    send_frame(10'h0F0, 1'b0, 1'b0, 1, 1'b0, 1'b1, "break");
    send_frame(10'h155, 1'b1, 1'b1, 1, 1'b0, 1'b0, "after_break");

    // Slow strobes with line noise between them.
    strobe(1'b1, 4);
    send_frame(10'h2AA, 1'b1, 1'b1, 4, 1'b0, 1'b0, "slow");
    strobe(1'b1, 4);

    // Async reset part-way through a frame.
    send_frame(10'h001, 1'b0, 1'b1, 1, 1'b1, 1'b0, "pre_rst");
    strobe(1'b1, 1);
    strobe(1'b0, 1);
    strobe(1'b1, 1);
    strobe(1'b0, 1);
    strobe(1'b1, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_data",  32'(data_out0), 32'd0);
    chk("midrst_valid", 32'(valid0), 32'd0);
    chk("midrst_perr",  32'(perr0), 32'd0);
    chk("midrst_ferr",  32'(ferr0), 32'd0);
    chk("midrst_busy",  32'(busy0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    v = vcnt0;
    for (int i = 0; i < 15; i++) strobe(1'b1, 1);
    chk("postrst_no_valid", 32'(vcnt0 - v), 32'd0);
    chk("postrst_busy", 32'(busy0), 32'd0);
    send_frame(10'h3C3, 1'b0, 1'b1, 1, 1'b0, 1'b0, "postrst");
    strobe(1'b1, 1);

    // Odd-parity instance, 200 back-to-back frames.
    dsel = 1'b1;
    v = vcnt1;
    for (int i = 0; i < 200; i++) begin
      dd = W'(i);
      send_frame(dd, ~^dd, 1'b1, 1, 1'b0, 1'b0, $sformatf("odd%0d", i));
    end
    strobe(1'b1, 1);
    chk("odd_valid_count", 32'(vcnt1 - v), 32'd200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
